// File: rtl/posit_defines.sv
// Shared posit sizing helpers and descriptor-type enum used across the posit datapath.
package posit_defines;

  typedef enum logic [1:0] {NORMAL, AADD, AMULT, ADIV} PD_TYPE;

  function automatic int get_max_scale(input int n, input int es);
    return (n - 2) << es;
  endfunction

  // Signed width covering +/-max scale, with headroom for arithmetic producers.
  function automatic int get_scale_width(input int n, input int es, input PD_TYPE t);
    int w;
    w = $clog2(get_max_scale(n, es) + 1) + 1;
    case (t)
      AADD:    w = w + 1;
      AMULT:   w = w + 1;
      ADIV:    w = w + 2;
      default: w = w;
    endcase
    return w;
  endfunction

  function automatic int get_fraction_width(input int n, input int es, input PD_TYPE t);
    int w;
    w = n - 3 - es;
    if (w < 1) w = 1;
    case (t)
      AMULT:   w = 2 * w + 2;
      default: w = w;
    endcase
    return w;
  endfunction

  function automatic logic [63:0] get_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/posit_round_nearest_even.sv
// Round-to-nearest-even on the magnitude field, saturating to [minpos, maxpos].
module posit_round_nearest_even
  import posit_defines::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] kept,
  input  logic             round_bit,
  input  logic             sticky,
  output logic [WIDTH-1:0] rounded
);

  logic up;

  always_comb begin
    up      = round_bit & (sticky | kept[0]);
    rounded = kept;
    // All-ones magnitude is maxpos; incrementing would wrap into NaR.
    if (up && (kept != '1)) rounded = kept + WIDTH'(1);
    if (rounded == '0) rounded = WIDTH'(1);
  end

endmodule

// File: rtl/posit_round_encode.sv
// Two-stage posit encoder: S1 packs regime/exponent/fraction, S2 rounds and applies sign.
// Optional out_flags {saturated, inexact} port under macro POSIT_ENCODE_FLAGS_EN.
module posit_round_encode
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 1
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic                                                   in_sign,
  input  logic                                                   in_zero,
  input  logic                                                   in_nar,
  input  logic [get_scale_width(POSIT_WIDTH, POSIT_ES, AADD)-1:0]      in_scale,
  input  logic [get_fraction_width(POSIT_WIDTH, POSIT_ES, NORMAL)-1:0] in_fraction,
  input  logic                                                   in_guard,
  input  logic                                                   in_round,
  input  logic                                                   in_sticky,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [POSIT_WIDTH-1:0]                                 out_posit
`ifdef POSIT_ENCODE_FLAGS_EN
  ,
  output logic [1:0]                                             out_flags
`endif
);

  localparam int N         = POSIT_WIDTH;
  localparam int ES        = POSIT_ES;
  localparam int SW        = get_scale_width(N, ES, AADD);
  localparam int FW        = get_fraction_width(N, ES, NORMAL);
  localparam int TW        = ES + FW + 3;
  localparam int LW        = N + TW;
  localparam int MAX_SCALE = get_max_scale(N, ES);
  localparam logic [63:0]  NAR_W = get_nar(N);
  localparam logic [N-1:0] NAR   = NAR_W[N-1:0];

  logic s1_valid, s2_valid, s1_advance, in_fire;
  logic s1_sign, s1_zero, s1_nar;
  logic [LW-1:0] s1_str;

  logic signed [SW-1:0] scale_c, k_c;
  logic [ES-1:0]        exp_c;
  logic                 sat_c;
  logic [TW-1:0]        tail_c;
  logic signed [LW-1:0] base_c;
  logic [SW-1:0]        shamt_c;
  logic [LW-1:0]        str_c;

  assign s1_advance = s1_valid & (~s2_valid | out_ready);
  assign in_ready   = ~s1_valid | s1_advance;
  assign in_fire    = in_valid & in_ready;
  assign out_valid  = s2_valid;

  always_comb begin
    sat_c   = 1'b0;
    scale_c = in_scale;
    if (int'($signed(in_scale)) > MAX_SCALE) begin
      sat_c   = 1'b1;
      scale_c = SW'(MAX_SCALE);
    end else if (int'($signed(in_scale)) < -MAX_SCALE) begin
      sat_c   = 1'b1;
      scale_c = SW'(-MAX_SCALE);
    end
    k_c    = scale_c >>> ES;
    exp_c  = scale_c[ES-1:0];
    tail_c = sat_c ? {exp_c, {(FW + 3){1'b0}}}
                   : {exp_c, in_fraction, in_guard, in_round, in_sticky};
    // Seed "10" (k>=0) or "01" (k<0); arithmetic shift replicates the seed MSB
    // to form k+1 ones or -k zeros ahead of the terminator.
    base_c  = {(k_c[SW-1] ? 2'b01 : 2'b10), tail_c, {(N - 2){1'b0}}};
    shamt_c = k_c[SW-1] ? ~k_c : k_c;
    str_c   = base_c >>> shamt_c;
  end

  logic [N-2:0] kept, rounded;
  logic         rnd, stk;
  logic [N-1:0] word_c;

  assign kept = s1_str[LW-1 -: N-1];
  assign rnd  = s1_str[LW-N];
  assign stk  = |s1_str[LW-N-1:0];

  posit_round_nearest_even #(.WIDTH(N - 1)) u_rne (
    .kept      (kept),
    .round_bit (rnd),
    .sticky    (stk),
    .rounded   (rounded)
  );

  always_comb begin
    word_c = {1'b0, rounded};
    if (s1_sign) word_c = -word_c;
    if (s1_nar)       word_c = NAR;
    else if (s1_zero) word_c = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_str    <= '0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_nar    <= 1'b0;
      out_posit <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_str   <= str_c;
        s1_sign  <= in_sign;
        s1_zero  <= in_zero;
        s1_nar   <= in_nar;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
      if (s1_advance) begin
        s2_valid  <= 1'b1;
        out_posit <= word_c;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef POSIT_ENCODE_FLAGS_EN
  logic s1_sat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sat    <= 1'b0;
      out_flags <= '0;
    end else begin
      if (in_fire) s1_sat <= sat_c;
      if (s1_advance) out_flags <= {s1_sat, rnd | stk | s1_sat};
    end
  end
`endif

endmodule

// File: tb/tb_posit_round_encode.sv
// Directed scoreboard bench for posit<8,1> encoding, backpressure and reset flush.
module tb_posit_round_encode;
  import posit_defines::*;

  localparam int N  = 8;
  localparam int ES = 1;
  localparam int SW = get_scale_width(N, ES, AADD);
  localparam int FW = get_fraction_width(N, ES, NORMAL);

  typedef struct {
    logic [N-1:0] posit;
    logic [1:0]   flags;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic          in_sign, in_zero, in_nar;
  logic [SW-1:0] in_scale;
  logic [FW-1:0] in_fraction;
  logic          in_guard, in_round, in_sticky;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_posit;
`ifdef POSIT_ENCODE_FLAGS_EN
  logic [1:0]    out_flags;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  posit_round_encode #(.POSIT_WIDTH(N), .POSIT_ES(ES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_zero     (in_zero),
    .in_nar      (in_nar),
    .in_scale    (in_scale),
    .in_fraction (in_fraction),
    .in_guard    (in_guard),
    .in_round    (in_round),
    .in_sticky   (in_sticky),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_posit   (out_posit)
`ifdef POSIT_ENCODE_FLAGS_EN
    ,
    .out_flags   (out_flags)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_output observed=%0h expected=none", out_posit);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_posit", 32'(out_posit), 32'(e.posit));
`ifdef POSIT_ENCODE_FLAGS_EN
        check("out_flags", 32'(out_flags), 32'(e.flags));
`endif
      end
    end
  end

  task automatic drive(input int sc, input logic [FW-1:0] fr, input logic [2:0] grs,
                       input logic [2:0] szn);
    in_scale    = sc[SW-1:0];
    in_fraction = fr;
    {in_guard, in_round, in_sticky} = grs;
    {in_sign, in_zero, in_nar}      = szn;
    in_valid    = 1'b1;
  endtask

  task automatic wait_accept(input logic [N-1:0] ep, input logic [1:0] ef);
    exp_t e;
    e.posit = ep;
    e.flags = ef;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
    end
    vectors++;
    miscompares++;
    $error("FAIL accept_timeout observed=stuck expected=in_ready");
  endtask

  task automatic send(input int sc, input logic [FW-1:0] fr, input logic [2:0] grs,
                      input logic [2:0] szn, input logic [N-1:0] ep, input logic [1:0] ef);
    drive(sc, fr, grs, szn);
    wait_accept(ep, ef);
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    in_scale = '0; in_fraction = '0;
    in_guard = 1'b0; in_round = 1'b0; in_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_posit", 32'(out_posit), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;

    // Streaming directed vectors, downstream always ready.
    send(  0, 4'b0000, 3'b000, 3'b000, 8'h40, 2'b00);
    send(  1, 4'b0000, 3'b000, 3'b000, 8'h50, 2'b00);
    send(  0, 4'b0000, 3'b000, 3'b100, 8'hC0, 2'b00);
    send(  0, 4'b0000, 3'b100, 3'b000, 8'h40, 2'b01);
    send(  0, 4'b0001, 3'b100, 3'b000, 8'h42, 2'b01);
    send( 20, 4'b0000, 3'b000, 3'b000, 8'h7F, 2'b11);
    send(-30, 4'b0000, 3'b000, 3'b000, 8'h01, 2'b11);
    send(  0, 4'b0000, 3'b000, 3'b011, 8'h80, 2'b00);
    send(  0, 4'b0000, 3'b000, 3'b010, 8'h00, 2'b00);
    send( -1, 4'b0000, 3'b000, 3'b000, 8'h30, 2'b00);
    send(  2, 4'b1111, 3'b100, 3'b000, 8'h68, 2'b01);
    send( 12, 4'b1111, 3'b100, 3'b000, 8'h7F, 2'b01);
    send(-12, 4'b0000, 3'b000, 3'b100, 8'hFF, 2'b00);
    send( 11, 4'b0000, 3'b000, 3'b000, 8'h7E, 2'b01);
    in_valid = 1'b0;
    drain();

    // Backpressure: two accepts fill both stages, then input stalls.
    out_ready = 1'b0;
    send(1, 4'b0000, 3'b000, 3'b000, 8'h50, 2'b00);
    send(0, 4'b0001, 3'b100, 3'b000, 8'h42, 2'b01);
    drive(-1, 4'b0000, 3'b000, 3'b000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_hold",      32'(out_posit), 32'h50);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept(8'h30, 2'b00);
    send(0, 4'b0000, 3'b000, 3'b100, 8'hC0, 2'b00);
    in_valid = 1'b0;
    drain();

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    send(20, 4'b0000, 3'b000, 3'b000, 8'h7F, 2'b11);
    send( 1, 4'b0000, 3'b000, 3'b000, 8'h50, 2'b00);
    in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_posit", 32'(out_posit), 32'd0);
    check("flush_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flush_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(-12, 4'b0000, 3'b000, 3'b000, 8'h01, 2'b00);
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
